serial_add_arbiter: RTL and testbench
=====================================

Name: serial_add_arbiter

Overview:
Sequences one shared bit-serial full-adder datapath (sum and carry logic plus a carry flop) between two requesters. Performs one WIDTH-bit add or subtract per grant, LSB first, one bit per cycle. Round-robin arbitration and a req/gnt/done handshake. Sits beside the in-order ALU as a low-area adder for non-critical address and counter updates.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  2  request per requester; req[i] high = requester i wants an operation
sub  input  2  sub[i]=1 selects A-B for requester i, 0 selects A+B
a0  input  WIDTH  operand A, requester 0
b0  input  WIDTH  operand B, requester 0
a1  input  WIDTH  operand A, requester 1
b1  input  WIDTH  operand B, requester 1
gnt  output  2  one-hot, one-cycle pulse marking the accepted requester
done  output  2  one-hot, one-cycle pulse marking result ready for that requester
busy  output  1  high while in RUN or DONE
result  output  WIDTH  last completed result; held until the next done
cout  output  1  final carry of the last completed operation (for sub: 1 = no borrow)

Behaviour:
- Reset values (asynchronous): state=IDLE; gnt=0, done=0, busy=0, result=0, cout=0; bit counter=0; carry flop=0; round-robin pointer favours requester 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, at a clock edge with any req bit high:
  - Select the winner: if only one req is high, that requester wins; if both are high, the requester not served last wins (requester 0 first after reset).
  - Latch the winner's A and B (B inverted when its sub=1) into shift registers.
  - Load the carry flop with the winner's sub value. Load counter=0. Go to RUN.
  - gnt[winner]=1 for exactly the first RUN cycle.
- RUN, per cycle:
  - Feed the LSBs of the A and B shift registers plus the carry flop into the full-adder function: S = A^B^C, Cout = majority(A,B,C).
  - Shift S into the result shift register from the MSB side. Shift the operand registers right. Register Cout into the carry flop.
  - Counter increments each cycle. After WIDTH RUN cycles (counter reached WIDTH-1 on the previous cycle), go to DONE.
- DONE, one cycle:
  - The result output takes the assembled word and cout takes the carry flop. Both are visible in this cycle and held afterwards.
  - done[winner]=1. Pointer records the winner. Next state is IDLE.
- Latency: accepting edge -> gnt during the next cycle; done asserts WIDTH+1 cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles.
- Handshake:
  - Requester holds req and its operands stable until gnt is seen. Operands are sampled only at the accepting edge.
  - req is ignored while busy.
  - A req still high when IDLE is re-entered is a new request and competes normally.
- gnt and done are never both high in the same cycle, and neither is ever high for both bits.
- Arithmetic is modulo 2^WIDTH. Examples: 0xFFFF+1 -> 0x0000 with cout=1; subtract by two's complement (invert B, carry-in 1).
- Reset mid-operation: immediate return to IDLE. No done pulse. result and cout cleared. The in-flight operation is lost and the requester must re-request.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit), registered and updated together with result. ovf = carry into MSB XOR carry out of MSB (signed overflow). Reset value 0.
- Undefined: no ovf port and no associated logic.

Test Plan:
- Reset, then req=01, sub=00, a0=0x0003, b0=0x0005 -> gnt=01 for one cycle; done=01 exactly 17 cycles after the accepting edge; result=0x0008, cout=0.
- req=10, sub=10, a1=0x0005, b1=0x0007 -> gnt=10; result=0xFFFE, cout=0; ovf=0 when SERIAL_ADD_OVF_EN is defined.
- Overflow and wrap cases:
  - a0=0xFFFF, b0=0x0001, add -> result=0x0000, cout=1, ovf=0.
  - a0=0x7FFF, b0=0x0001 -> result=0x8000, ovf=1.
- req=11 held continuously after reset (a0=1, b0=1, a1=2, b1=2, add):
  - Order is gnt=01, done=01 (result 0x0002), then gnt=10, done=10 (result 0x0004), then requester 0 again.
  - busy stays high through each operation.
- Accept a request; while busy, raise the other req for 5 cycles then drop it -> no gnt for that requester; only the original done fires.
- Assert reset 8 cycles into RUN -> busy=0, result=0, cout=0 immediately; no done pulse. Next request after reset is granted to requester 0 when both request.

Source files
------------

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter sharing one bit-serial full adder (add/sub, LSB first).
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [1:0]       sub,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             carry;
   logic             winner, win_next;
   logic             last;
   logic             accept, last_bit;
   logic [1:0]       fa;
   logic [WIDTH-1:0] op_a, op_b;
   logic             op_sub;

   // {carry_out, sum} of one full-adder bit
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   // Next-state, winner selection and operand mux
   always_comb begin
      state_next = state;
      win_next   = winner;
      accept     = 1'b0;
      last_bit   = 1'b0;
      fa         = full_add(a_sr[0], b_sr[0], carry);
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               accept     = 1'b1;
               state_next = RUN;
               if (req == 2'b11) begin
                  win_next = ~last;
               end else begin
                  win_next = req[1];
               end
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (count == CW'(WIDTH - 1)) begin
               last_bit   = 1'b1;
               state_next = DONE;
            end else begin
               state_next = RUN;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (win_next) begin
         op_a   = a1;
         op_b   = b1;
         op_sub = sub[1];
      end else begin
         op_a   = a0;
         op_b   = b0;
         op_sub = sub[0];
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Serial datapath, handshake pulses and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         winner <= 1'b0;
         last   <= 1'b1;
         gnt    <= 2'b00;
         done   <= 2'b00;
         busy   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         gnt  <= accept ? (win_next ? 2'b10 : 2'b01) : 2'b00;
         done <= last_bit ? (winner ? 2'b10 : 2'b01) : 2'b00;
         busy <= (state_next != IDLE);
         if (accept) begin
            winner <= win_next;
            a_sr   <= op_a;
            b_sr   <= op_b ^ {WIDTH{op_sub}};
            carry  <= op_sub;
            count  <= '0;
         end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa[0], res_sr[WIDTH-1:1]};
            carry  <= fa[1];
            count  <= count + CW'(1);
         end else begin
            count  <= count;
         end
         // Final bit goes straight to the outputs so they are valid in the DONE cycle
         if (last_bit) begin
            result <= {fa[0], res_sr[WIDTH-1:1]};
            cout   <= fa[1];
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= carry ^ fa[1];
`endif
         end else begin
            cout   <= cout;
         end
         if (state == DONE) begin
            last <= winner;
         end else begin
            last <= last;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: vector table plus multi-cycle corner sequences.
module tb_serial_add_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req, sub;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   gnt, done;
   logic         busy, cout, ovf;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         who;
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         o;
   } vec_t;

   typedef struct {
      logic         who;
      logic [W-1:0] res;
      logic         c;
      logic         o;
   } exp_t;

   vec_t         vecs[8];
   exp_t         sb[$];
   logic [W-1:0] exp_prev;

   serial_add_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req(req), .sub(sub),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt(gnt), .done(done), .busy(busy), .result(result), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf(ovf)
`endif
   );
`ifndef SERIAL_ADD_OVF_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Handshake pulses must stay one-hot and never overlap
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ((gnt == 2'b11) || (done == 2'b11) || ((gnt != 2'b00) && (done != 2'b00))) begin
            errors++;
            $display("FAIL pulse_exclusive actual gnt=%b done=%b required one-hot, disjoint", gnt, done);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = 2'b00;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_result", {16'd0, result}, 32'd0);
      chk("reset_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      exp_prev = '0;
   endtask

   task automatic wait_gnt(output logic [1:0] g);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt == 2'b00 && n < 50);
      if (gnt == 2'b00) begin
         errors++;
         $display("FAIL gnt_timeout actual=none required=gnt within 50 cycles");
      end
      g = gnt;
   endtask

   // Called in the gnt cycle; returns the cycle index (gnt cycle = 1) at which done was seen
   task automatic wait_done(input bit drop_other, output int cyc);
      bit bad = 1'b0;
      cyc = 1;
      while (done == 2'b00 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (drop_other) begin
            req = (cyc >= 2 && cyc <= 6) ? 2'b10 : 2'b00;
         end
         if (!busy || (cyc > 1 && gnt != 2'b00)) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL busy_no_regrant actual=busy low or extra gnt required=busy high, no gnt");
      end
   endtask

   task automatic check_done(input string tag, input int cyc);
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_sb actual=empty required=pending entry", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc, 32'd17);
      chk({tag, "_done"}, {30'd0, done}, e.who ? 32'd2 : 32'd1);
      chk({tag, "_result"}, {16'd0, result}, {16'd0, e.res});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.o});
`endif
      exp_prev = e.res;
      @(negedge clk);
      chk({tag, "_done_pulse"}, {30'd0, done}, 32'd0);
      chk({tag, "_held"}, {16'd0, result}, {16'd0, exp_prev});
   endtask

   task automatic do_op(input vec_t v);
      logic [1:0] g;
      int         cyc;
      exp_t       e;
      @(negedge clk);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      if (v.who) begin
         a1 = v.a; b1 = v.b; req = 2'b10; sub = {v.s, 1'b0};
      end else begin
         a0 = v.a; b0 = v.b; req = 2'b01; sub = {1'b1, v.s};
      end
      e.who = v.who; e.res = v.res; e.c = v.c; e.o = v.o;
      sb.push_back(e);
      @(negedge clk);
      g = gnt;
      chk("op_gnt", {30'd0, g}, v.who ? 32'd2 : 32'd1);
      chk("op_prev_held", {16'd0, result}, {16'd0, exp_prev});
      req = 2'b00;
      wait_done(1'b0, cyc);
      check_done("op", cyc);
   endtask

   initial begin
      logic [1:0] g;
      int         cyc;
      exp_t       e;
      bit         bad;

      vecs[0] = '{1'b0, 1'b0, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};

      reset = 1'b1; req = 2'b00; sub = 2'b00;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      exp_prev = '0;
      #1;
      chk("por_gnt", {30'd0, gnt}, 32'd0);
      chk("por_done", {30'd0, done}, 32'd0);
      do_reset();

      for (int i = 0; i < 8; i++) do_op(vecs[i]);

      // Both requesting continuously: strict alternation starting with requester 0
      do_reset();
      @(negedge clk);
      a0 = 16'd1; b0 = 16'd1; a1 = 16'd2; b1 = 16'd2; sub = 2'b00; req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(g);
         chk("rr_gnt", {30'd0, g}, (k % 2 == 1) ? 32'd2 : 32'd1);
         e.who = (k % 2 == 1); e.res = (k % 2 == 1) ? 16'd4 : 16'd2; e.c = 1'b0; e.o = 1'b0;
         sb.push_back(e);
         if (k == 2) req = 2'b00;
         wait_done(1'b0, cyc);
         check_done("rr", cyc);
      end

      // Competing request raised while busy is ignored
      @(negedge clk);
      a0 = 16'h0010; b0 = 16'h0020; sub = 2'b00; req = 2'b01;
      e.who = 1'b0; e.res = 16'h0030; e.c = 1'b0; e.o = 1'b0;
      sb.push_back(e);
      wait_gnt(g);
      chk("busy_gnt", {30'd0, g}, 32'd1);
      req = 2'b00;
      wait_done(1'b1, cyc);
      check_done("busy", cyc);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (gnt != 2'b00 || done != 2'b00) bad = 1'b1;
      end
      chk("busy_no_late_gnt", {31'd0, bad}, 32'd0);

      // Reset eight cycles into RUN drops the operation and restores priority to requester 0
      @(negedge clk);
      a1 = 16'h1234; b1 = 16'h4321; sub = 2'b00; req = 2'b10;
      wait_gnt(g);
      chk("midrst_gnt", {30'd0, g}, 32'd2);
      req = 2'b00;
      repeat (7) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_result", {16'd0, result}, 32'd0);
      chk("midrst_cout", {31'd0, cout}, 32'd0);
      chk("midrst_done", {30'd0, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_prev = '0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done != 2'b00 || busy) bad = 1'b1;
      end
      chk("midrst_no_done", {31'd0, bad}, 32'd0);
      a0 = 16'h0100; b0 = 16'h0001; a1 = 16'h0200; b1 = 16'h0002; sub = 2'b00; req = 2'b11;
      e.who = 1'b0; e.res = 16'h0101; e.c = 1'b0; e.o = 1'b0;
      sb.push_back(e);
      wait_gnt(g);
      chk("midrst_rr", {30'd0, g}, 32'd1);
      req = 2'b00;
      wait_done(1'b0, cyc);
      check_done("post_rst", cyc);

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
